// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a free-running 16x oversampling tick generator.
// Data is shifted out LSB first from a byte captured when the request is accepted.
module uart_tx #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned M       = 163,
    parameter int unsigned N       = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_done_tick,
    output logic            tx_busy
);

    localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            s_tick;
    logic            done;

    // Baud generator is never restarted by a request, so frame start may jitter by M-1 clocks.
    assign s_tick = (cnt_q == N'(M - 1));
    assign cnt_d  = s_tick ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_start) begin
                    b_d     = din;
                    s_d     = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = StData;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = StStop;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level follows the next state so tx comes straight from a flop.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = b_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end

    // Done pulse is same-cycle so a host holding tx_start sees exactly one idle clock.
    assign tx           = tx_q;
    assign tx_done_tick = done;
    assign tx_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame vectors, back-to-back, busy-ignore, reset
// mid-frame, 2-stop-bit timing and the baud tick period.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, start0, tx0, done0, busy0;
    logic [7:0] din0;
    logic       rst1, start1, tx1, done1, busy1;
    logic [7:0] din1;
    logic       rst2, start2, tx2, done2, busy2;
    logic [7:0] din2;

    uart_tx #(.DBIT(8), .SB_TICK(16), .M(4), .N(8)) dut0 (
        .clk(clk), .reset(rst0), .tx_start(start0), .din(din0),
        .tx(tx0), .tx_done_tick(done0), .tx_busy(busy0)
    );
    uart_tx #(.DBIT(8), .SB_TICK(32), .M(4), .N(8)) dut1 (
        .clk(clk), .reset(rst1), .tx_start(start1), .din(din1),
        .tx(tx1), .tx_done_tick(done1), .tx_busy(busy1)
    );
    uart_tx #(.DBIT(8), .SB_TICK(16), .M(163), .N(8)) dut2 (
        .clk(clk), .reset(rst2), .tx_start(start2), .din(din2),
        .tx(tx2), .tx_done_tick(done2), .tx_busy(busy2)
    );

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    int ticks = 0;
    int last_tick = -1;
    int bad_per = 0;
    int max_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done0) done_cnt0 <= done_cnt0 + 1;
        if (done1) done_cnt1 <= done_cnt1 + 1;
    end

    always @(negedge clk) begin
        if (rst2) begin
            if (int'(dut2.cnt_q) > max_cnt) max_cnt <= int'(dut2.cnt_q);
            if (dut2.s_tick) begin
                if (last_tick >= 0 && (cyc - last_tick) != 163) bad_per <= bad_per + 1;
                last_tick <= cyc;
                ticks     <= ticks + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse tx_start for one clock; returns at the negedge after acceptance.
    task automatic accept(input int sel, input logic [7:0] d, input string name);
        @(negedge clk);
        if (sel == 1) begin start1 = 1'b1; din1 = d; end
        else begin start0 = 1'b1; din0 = d; end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        check($sformatf("%s accept busy", name), (sel == 1) ? busy1 : busy0, 1'b1);
    endtask

    // Starts at the acceptance negedge; samples mid-bit and ends at the done negedge.
    task automatic run_body(input int sel, input logic [9:0] exp, input int exp_lat,
                            input string name);
        int t;
        t = 0;
        for (int i = 0; i < 10; i++) begin
            while (t < 28 + 64 * i) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("%s bit%0d", name, i), (sel == 1) ? tx1 : tx0, exp[i]);
        end
        while (!((sel == 1) ? done1 : done0) && t < 800) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t + 1 < exp_lat - 3 || t + 1 > exp_lat + 3) begin
            errors++;
            $display("FAIL %s done latency: got %0d clks, expected %0d +/- 3", name, t + 1,
                     exp_lat);
        end
    endtask

    typedef struct {
        int         sel;
        logic [7:0] din;
        logic [9:0] frame;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int d0;
        int guard;
        logic [7:0] b2b_din[3];
        logic [9:0] b2b_exp[3];

        vecs[0] = '{0, 8'h41, 10'b1_01000001_0, 640};
        vecs[1] = '{0, 8'h3A, 10'b1_00111010_0, 640};
        vecs[2] = '{0, 8'h0D, 10'b1_00001101_0, 640};
        vecs[3] = '{0, 8'h00, 10'b1_00000000_0, 640};
        vecs[4] = '{0, 8'hFF, 10'b1_11111111_0, 640};
        vecs[5] = '{0, 8'h80, 10'b1_10000000_0, 640};
        vecs[6] = '{1, 8'h00, 10'b1_00000000_0, 704};
        vecs[7] = '{1, 8'hA5, 10'b1_10100101_0, 704};
        b2b_din[0] = 8'h41; b2b_exp[0] = 10'b1_01000001_0;
        b2b_din[1] = 8'h3A; b2b_exp[1] = 10'b1_00111010_0;
        b2b_din[2] = 8'h0D; b2b_exp[2] = 10'b1_00001101_0;

        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        din0 = 8'h00; din1 = 8'h00; din2 = 8'h00;

        repeat (3) @(negedge clk);
        check("reset tx", tx0, 1'b1);
        check("reset busy", busy0, 1'b0);
        check("reset done", done0, 1'b0);
        check("reset tx sb32", tx1, 1'b1);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            d0 = (vecs[v].sel == 1) ? done_cnt1 : done_cnt0;
            accept(vecs[v].sel, vecs[v].din, $sformatf("vec%0d", v));
            run_body(vecs[v].sel, vecs[v].frame, vecs[v].lat, $sformatf("vec%0d", v));
            @(negedge clk);
            check($sformatf("vec%0d done width", v), (vecs[v].sel == 1) ? done1 : done0, 1'b0);
            check($sformatf("vec%0d idle busy", v), (vecs[v].sel == 1) ? busy1 : busy0, 1'b0);
            check($sformatf("vec%0d idle tx", v), (vecs[v].sel == 1) ? tx1 : tx0, 1'b1);
            check($sformatf("vec%0d done count", v),
                  ((vecs[v].sel == 1) ? done_cnt1 : done_cnt0) - d0, 1);
        end

        // Back-to-back with tx_start held and din swapped on each done pulse.
        d0 = done_cnt0;
        @(negedge clk);
        din0 = b2b_din[0];
        start0 = 1'b1;
        @(negedge clk);
        check("b2b accept0", busy0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            run_body(0, b2b_exp[f], 640, $sformatf("b2b%0d", f));
            if (f < 2) din0 = b2b_din[f + 1];
            else start0 = 1'b0;
            @(negedge clk);
            check($sformatf("b2b%0d gap busy", f), busy0, 1'b0);
            check($sformatf("b2b%0d gap tx", f), tx0, 1'b1);
            if (f < 2) begin
                @(negedge clk);
                check($sformatf("b2b%0d next accept", f), busy0, 1'b1);
            end
        end
        repeat (10) @(negedge clk);
        check("b2b done count", done_cnt0 - d0, 3);
        check("b2b stays idle", busy0, 1'b0);

        // Request while busy must be ignored.
        d0 = done_cnt0;
        accept(0, 8'h55, "ign");
        fork
            run_body(0, 10'b1_01010101_0, 640, "ign");
            begin
                repeat (200) @(negedge clk);
                start0 = 1'b1;
                din0 = 8'hFF;
                @(negedge clk);
                start0 = 1'b0;
            end
        join
        repeat (30) @(negedge clk);
        check("ign done count", done_cnt0 - d0, 1);
        check("ign idle after", busy0, 1'b0);

        // Reset during data bit 3, then restart with tx_start held through release.
        accept(0, 8'h55, "rst");
        repeat (284) @(negedge clk);
        d0 = done_cnt0;
        #1 rst0 = 1'b0;
        #1;
        check("rst async tx", tx0, 1'b1);
        check("rst async busy", busy0, 1'b0);
        check("rst async done", done0, 1'b0);
        start0 = 1'b1;
        din0 = 8'h30;
        @(negedge clk);
        check("rst held busy", busy0, 1'b0);
        rst0 = 1'b1;
        @(negedge clk);
        check("rst restart busy", busy0, 1'b1);
        start0 = 1'b0;
        run_body(0, 10'b1_00110000_0, 640, "rst30");
        @(negedge clk);
        check("rst done count", done_cnt0 - d0, 1);

        // Let the M=163 generator accumulate enough ticks for the period check.
        guard = 0;
        while (ticks < 250 && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        check("baud tick budget", (ticks >= 250) ? 1 : 0, 1);
        check("baud period errors", bad_per, 0);
        check("baud max count", max_cnt, 162);
        check("baud dut idle tx", tx2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
